// File: rtl/bsm_sched.sv
// Round-robin front end that time-shares one bit-serial multiplier among NREQ
// requesters: latch operands, stream them LSB-first, return the product tagged by id.
module bsm_sched #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int WW      = 5,
  parameter int TIMEOUT = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DW-1:0]       req_a,
  input  logic [NREQ*DW-1:0]       req_b,
  input  logic [NREQ*WW-1:0]       req_wa,
  input  logic [NREQ*WW-1:0]       req_wb,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DW-1:0]            rsp_data,
  output logic                     rsp_err,
  output logic                     bsm_start,
  output logic [WW-1:0]            bsm_wa,
  output logic [WW-1:0]            bsm_wb,
  output logic                     bsm_bita,
  output logic                     bsm_bitb,
  input  logic [DW-1:0]            bsm_o,
  input  logic                     bsm_done
);

  localparam int IDW = $clog2(NREQ);
  localparam int KW  = $clog2(DW);
  localparam int TW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, SHIFT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [WW-1:0]   wa_q, wa_d, wb_q, wb_d;
  logic [KW-1:0]   k_q, k_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic            err_q, err_d;

  logic [DW-1:0]   a_arr  [NREQ];
  logic [DW-1:0]   b_arr  [NREQ];
  logic [WW-1:0]   wa_arr [NREQ];
  logic [WW-1:0]   wb_arr [NREQ];
  logic [NREQ-1:0] rdy;
  logic            gnt_found;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign a_arr[gi]  = req_a[gi*DW +: DW];
    assign b_arr[gi]  = req_b[gi*DW +: DW];
    assign wa_arr[gi] = req_wa[gi*WW +: WW];
    assign wb_arr[gi] = req_wb[gi*WW +: WW];
  end

  // Search starts just after the last-served requester, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int j = 1; j <= NREQ; j++) begin
      idx = IDW'((int'(ptr_q) + j) % NREQ);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    wa_d      = wa_q;
    wb_d      = wb_q;
    k_d       = k_q;
    tcnt_d    = tcnt_q;
    data_d    = data_q;
    err_d     = err_q;
    rdy       = '0;
    rsp_valid = 1'b0;
    bsm_start = 1'b0;
    bsm_bita  = 1'b0;
    bsm_bitb  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          rdy[gnt_id] = 1'b1;
          id_d   = gnt_id;
          a_d    = a_arr[gnt_id];
          b_d    = b_arr[gnt_id];
          wa_d   = wa_arr[gnt_id];
          wb_d   = wb_arr[gnt_id];
          k_d    = '0;
          tcnt_d = '0;
          if (wa_arr[gnt_id] == '0 || wb_arr[gnt_id] == '0) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        bsm_start = 1'b1;
        bsm_bita  = a_q[0];
        bsm_bitb  = b_q[0];
        k_d       = KW'(1);
        tcnt_d    = TW'(1);
        state_d   = SHIFT;
      end
      SHIFT: begin
        // k saturates at the MSB, so the sign bit repeats for long widths.
        bsm_bita = a_q[k_q];
        bsm_bitb = b_q[k_q];
        if (k_q != KW'(DW-1)) k_d = k_q + KW'(1);
        tcnt_d = tcnt_q + TW'(1);
        if (bsm_done) begin
          data_d  = bsm_o;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tcnt_q == TW'(TIMEOUT-1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          ptr_d   = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // req_ready is combinational, so it is gated to keep every output low in reset.
  assign req_ready = rst ? '0 : rdy;
  assign rsp_id    = (state_q == RESP) ? id_q   : '0;
  assign rsp_data  = (state_q == RESP) ? data_q : '0;
  assign rsp_err   = (state_q == RESP) ? err_q  : 1'b0;
  assign bsm_wa    = wa_q;
  assign bsm_wb    = wb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ-1);
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wa_q    <= '0;
      wb_q    <= '0;
      k_q     <= '0;
      tcnt_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
      k_q     <= k_d;
      tcnt_q  <= tcnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule
